// File: rtl/ltc_frame_sequencer_pkg.sv
// Shared constants, state type and sync-field helper for the LTC frame sequencer.
package ltc_pkg;

  localparam logic [1:0] FR_24  = 2'b00;
  localparam logic [1:0] FR_25  = 2'b01;
  localparam logic [1:0] FR_30  = 2'b11;
  localparam logic [1:0] FR_BAD = 2'b10;

  localparam int unsigned FRAME_DATA_W = 64;
  localparam int unsigned SYNC_W       = 16;
  localparam int unsigned FRAME_W      = 80;
  localparam int unsigned BIT_IDX_W    = 7;
  localparam int unsigned CNT_W        = 16;

  // Half-bit periods in 12 MHz clk cycles
  localparam int unsigned HALF_24_DEF = 3125;
  localparam int unsigned HALF_25_DEF = 3000;
  localparam int unsigned HALF_30_DEF = 2500;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(79);

  // Sync word written in transmit order: leftmost digit is bit 64
  localparam logic [SYNC_W-1:0] SYNC_WORD = 16'b0011111111111101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Reorders SYNC_WORD so that field bit 0 (frame bit 64) is the first digit sent
  function automatic logic [SYNC_W-1:0] sync_field();
    logic [SYNC_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SYNC_W); i++) begin
      r[i] = SYNC_WORD[int'(SYNC_W) - 1 - i];
    end
    return r;
  endfunction

  localparam logic [SYNC_W-1:0] SYNC_FIELD = sync_field();

endpackage

// File: rtl/ltc_frame_sequencer_if.sv
// Frame-word handshake between the timecode counter (master) and the sequencer (slave).
//   frame_data  : LTC bits 0..63, bit 0 sent first
//   frame_valid : frame_data valid
//   frame_ready : sequencer shadow register empty
interface ltc_frame_sequencer_if;
  logic [ltc_pkg::FRAME_DATA_W-1:0] frame_data;
  logic                             frame_valid;
  logic                             frame_ready;

  modport master (output frame_data, output frame_valid, input  frame_ready);
  modport slave  (input  frame_data, input  frame_valid, output frame_ready);
endinterface

// File: rtl/ltc_frame_sequencer_bit_timer.sv
// Half-bit timer: counts down from half-1 to 0 and ticks on 0.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : restart at half-1 in the first half of a bit, latching half
//   run          : count enable
//   half         : half-period in clk cycles, sampled on load
//   half_tick_c  : combinational, high on the last cycle of each half-bit
//   phase        : 0 = first half of the bit, 1 = second half
module ltc_bit_timer
  import ltc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             half_tick_c,
  output logic             phase
);

  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] cnt;

  assign half_tick_c = run && (cnt == '0);

  // Half period is held from load so mid-frame rate changes cannot reach it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_q <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
    end else if (load) begin
      half_q <= half;
      cnt    <= half - CNT_W'(1);
      phase  <= 1'b0;
    end else if (half_tick_c) begin
      cnt    <= half_q - CNT_W'(1);
      phase  <= ~phase;
    end else if (run) begin
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ltc_frame_sequencer.sv
// LTC frame sequencer: buffers one 64-bit frame word, appends the sync field,
// paces 80-bit frames at the selected rate and biphase-mark encodes onto timecode.
//   clk, reset_n : 12 MHz clock, synchronous active-low reset
//   enable       : transmit enable, sampled at frame boundaries
//   framerate    : 00=24, 01=25, 11=30 fps, 10=invalid
//   frm          : frame word handshake (slave side)
//   frame_start  : pulse with the first cycle of bit 0
//   underrun     : pulse at a boundary that had to resend the previous word
//   bit_index    : bit being sent (0..79)
//   busy         : high while transmitting
//   timecode     : biphase-mark output
module ltc_frame_sequencer
  import ltc_pkg::*;
#(
  parameter int unsigned HALF_24 = HALF_24_DEF,
  parameter int unsigned HALF_25 = HALF_25_DEF,
  parameter int unsigned HALF_30 = HALF_30_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           framerate,
  ltc_frame_sequencer_if.slave frm,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [BIT_IDX_W-1:0] bit_index,
  output logic                 busy,
  output logic                 timecode
);

  state_t                  state, state_n;
  logic [FRAME_W-1:0]      shift_q, shift_n;
  logic [FRAME_DATA_W-1:0] shadow_q;
  logic                    shadow_full, shadow_full_n;
  logic                    frame_start_n, underrun_n, timecode_n;
  logic [BIT_IDX_W-1:0]    bit_index_n;
  logic                    transfer, timer_load, run_c;
  logic                    half_tick_c, phase;
  logic [CNT_W-1:0]        half_sel;
  logic                    rate_ok, load;

  assign rate_ok       = enable && (framerate != FR_BAD);
  assign load          = frm.frame_valid && frm.frame_ready;
  assign run_c         = (state == RUN);
  assign shadow_full_n = (shadow_full && !transfer) || load;

  // Half period for the frame about to start
  always_comb begin
    case (framerate)
      FR_24:   half_sel = CNT_W'(HALF_24);
      FR_30:   half_sel = CNT_W'(HALF_30);
      default: half_sel = CNT_W'(HALF_25);
    endcase
  end

  ltc_bit_timer u_bit_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (timer_load),
    .run         (run_c),
    .half        (half_sel),
    .half_tick_c (half_tick_c),
    .phase       (phase)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      shift_q         <= '0;
      shadow_q        <= '0;
      shadow_full     <= 1'b0;
      frm.frame_ready <= 1'b1;
      frame_start     <= 1'b0;
      underrun        <= 1'b0;
      bit_index       <= '0;
      busy            <= 1'b0;
      timecode        <= 1'b0;
    end else begin
      state           <= state_n;
      shift_q         <= shift_n;
      shadow_full     <= shadow_full_n;
      frm.frame_ready <= !shadow_full_n;
      frame_start     <= frame_start_n;
      underrun        <= underrun_n;
      bit_index       <= bit_index_n;
      busy            <= (state_n == RUN);
      timecode        <= timecode_n;
      if (load) begin
        shadow_q <= frm.frame_data;
      end
    end
  end

  // Next state, shift register and encoder; the shift register rotates so that
  // after 80 bits it again holds the word just sent, ready for an underrun resend
  always_comb begin
    state_n       = state;
    shift_n       = shift_q;
    timecode_n    = timecode;
    bit_index_n   = bit_index;
    frame_start_n = 1'b0;
    underrun_n    = 1'b0;
    transfer      = 1'b0;
    timer_load    = 1'b0;
    case (state)
      IDLE: begin
        if (rate_ok) state_n = WAIT;
      end
      WAIT: begin
        if (!rate_ok) begin
          state_n = IDLE;
        end else if (shadow_full) begin
          state_n       = RUN;
          transfer      = 1'b1;
          shift_n       = {SYNC_FIELD, shadow_q};
          frame_start_n = 1'b1;
          bit_index_n   = '0;
          timecode_n    = ~timecode;
          timer_load    = 1'b1;
        end
      end
      RUN: begin
        if (half_tick_c) begin
          if (!phase) begin
            // Mid-bit: a one carries an extra transition
            if (shift_q[0]) timecode_n = ~timecode;
          end else begin
            shift_n = {shift_q[0], shift_q[FRAME_W-1:1]};
            if (bit_index != LAST_BIT) begin
              bit_index_n = bit_index + BIT_IDX_W'(1);
              timecode_n  = ~timecode;
            end else if (!rate_ok) begin
              state_n     = IDLE;
              bit_index_n = '0;
            end else begin
              frame_start_n = 1'b1;
              bit_index_n   = '0;
              timecode_n    = ~timecode;
              timer_load    = 1'b1;
              if (shadow_full) begin
                transfer = 1'b1;
                shift_n  = {SYNC_FIELD, shadow_q};
              end else begin
                underrun_n = 1'b1;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ltc_frame_sequencer.sv
// Self-checking bench for ltc_frame_sequencer with shortened half-bit periods.
module tb_ltc_frame_sequencer;

  localparam int unsigned H24 = 7;
  localparam int unsigned H25 = 5;
  localparam int unsigned H30 = 3;
  // Sync digits in the order they go on the wire: bit 64 first
  localparam logic [15:0] SYNC_TX = 16'b0011111111111101;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_SEND  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] framerate = 2'b01;
  logic       frame_start, underrun, busy, timecode;
  logic [6:0] bit_index;

  ltc_frame_sequencer_if frm();

  ltc_frame_sequencer #(
    .HALF_24 (H24),
    .HALF_25 (H25),
    .HALF_30 (H30)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .framerate   (framerate),
    .frm         (frm),
    .frame_start (frame_start),
    .underrun    (underrun),
    .bit_index   (bit_index),
    .busy        (busy),
    .timecode    (timecode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode = M_OFF;
  int          m_t, m_h, m_bidx;
  logic [79:0] m_word;
  logic [63:0] m_shadow;
  bit          m_full, m_level, m_fs, m_ur;
  bit          mv_ok, mv_hs, mv_prev_full, mv_took;
  logic [63:0] mv_prev_shadow;

  function automatic int half_for(input logic [1:0] fr);
    case (fr)
      2'b00:   return int'(H24);
      2'b01:   return int'(H25);
      2'b11:   return int'(H30);
      default: return 0;
    endcase
  endfunction

  function automatic logic [79:0] make_word(input logic [63:0] d);
    logic [79:0] w;
    w[63:0] = d;
    for (int k = 0; k < 16; k++) w[64 + k] = SYNC_TX[15 - k];
    return w;
  endfunction

  // Frame-relative time t: bit t/(2H) is on the wire; edges at t%(2H)==0, ones also at H
  always @(posedge clk) begin
    mv_ok          = enable && (framerate != 2'b10);
    mv_hs          = frm.frame_valid && !m_full;
    mv_prev_full   = m_full;
    mv_prev_shadow = m_shadow;
    mv_took        = 1'b0;
    m_fs           = 1'b0;
    m_ur           = 1'b0;
    if (!reset_n) begin
      m_mode  = M_OFF;
      m_full  = 1'b0;
      m_level = 1'b0;
      m_t     = 0;
      m_bidx  = 0;
    end else begin
      case (m_mode)
        M_OFF: if (mv_ok) m_mode = M_ARMED;
        M_ARMED: begin
          if (!mv_ok) m_mode = M_OFF;
          else if (mv_prev_full) begin
            m_word  = make_word(mv_prev_shadow);
            mv_took = 1'b1;
            m_t     = 0;
            m_h     = half_for(framerate);
            m_level = !m_level;
            m_fs    = 1'b1;
            m_bidx  = 0;
            m_mode  = M_SEND;
          end
        end
        default: begin
          m_t++;
          if (m_t == 160 * m_h) begin
            if (!mv_ok) begin
              m_mode = M_OFF;
              m_bidx = 0;
            end else begin
              if (mv_prev_full) begin
                m_word  = make_word(mv_prev_shadow);
                mv_took = 1'b1;
              end else begin
                m_ur = 1'b1;
              end
              m_t     = 0;
              m_h     = half_for(framerate);
              m_level = !m_level;
              m_fs    = 1'b1;
              m_bidx  = 0;
            end
          end else begin
            if (m_t % (2 * m_h) == 0) m_level = !m_level;
            else if (m_t % (2 * m_h) == m_h && m_word[m_t / (2 * m_h)]) m_level = !m_level;
            m_bidx = m_t / (2 * m_h);
          end
        end
      endcase
      if (mv_took) m_full = 1'b0;
      if (mv_hs) begin
        m_shadow = frm.frame_data;
        m_full   = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check_eq("timecode",    64'(timecode),        64'(m_level));
    check_eq("frame_start", 64'(frame_start),     64'(m_fs));
    check_eq("underrun",    64'(underrun),        64'(m_ur));
    check_eq("bit_index",   64'(bit_index),       64'(m_bidx));
    check_eq("busy",        64'(busy),            64'(m_mode == M_SEND));
    check_eq("frame_ready", 64'(frm.frame_ready), 64'(!m_full));
  end

  // ---------------- producer ----------------
  logic [63:0] data_q[$];
  bit          prod_on = 1'b0;

  initial begin : producer
    bit armed;
    int gap;
    armed = 1'b0;
    gap   = 0;
    frm.frame_valid = 1'b0;
    frm.frame_data  = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        frm.frame_valid = 1'b0;
        gap = $urandom_range(0, 3);
      end
      if (!frm.frame_valid) begin
        if (gap > 0) gap--;
        else if (prod_on) begin
          frm.frame_valid = 1'b1;
          if (data_q.size() > 0) frm.frame_data = data_q.pop_front();
          else frm.frame_data = {$urandom, $urandom};
        end
      end
      armed = frm.frame_valid && frm.frame_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_fs(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Called on a frame_start cycle; counts cycles to the next frame_start
  task automatic measure(input int switch_at, input logic [1:0] new_fr,
                         output int n, output int ur);
    n  = 0;
    ur = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n++;
      if (underrun) ur++;
      if (n == switch_at) framerate = new_fr;
      if (frame_start) break;
    end
  endtask

  initial begin : main
    bit          seen;
    int          n, ur, ur_total;
    logic        tc_hold;
    logic [1:0]  fr_pick;

    repeat (4) @(negedge clk);
    check_eq("rst_timecode", 64'(timecode), 64'(0));
    check_eq("rst_ready",    64'(frm.frame_ready), 64'(1));
    check_eq("rst_busy",     64'(busy), 64'(0));
    reset_n = 1'b1;

    // 25 fps, first word all zeros
    data_q.push_back(64'h0);
    prod_on   = 1'b1;
    framerate = 2'b01;
    enable    = 1'b1;
    wait_fs(seen);
    check_eq("t1_first_fs", 64'(seen), 64'(1));
    measure(-1, 2'b01, n, ur);
    check_eq("t1_period", 64'(n), 64'(160 * H25));

    // Mid-frame switch to 30 fps
    measure(300, 2'b11, n, ur);
    check_eq("t4_switch_period", 64'(n), 64'(160 * H25));
    measure(-1, 2'b11, n, ur);
    check_eq("t4_new_period", 64'(n), 64'(160 * H30));

    // 24 fps with a single-one word queued
    data_q.push_back(64'h1);
    framerate = 2'b00;
    measure(-1, 2'b00, n, ur);
    check_eq("t2_last30", 64'(n), 64'(160 * H30));
    measure(-1, 2'b00, n, ur);
    check_eq("t2_period24", 64'(n), 64'(160 * H24));
    measure(-1, 2'b00, n, ur);
    check_eq("t2_period24b", 64'(n), 64'(160 * H24));

    // Starve the shadow register
    prod_on  = 1'b0;
    ur_total = 0;
    for (int f = 0; f < 4; f++) begin
      measure(-1, 2'b00, n, ur);
      ur_total += ur;
    end
    check_eq("t3_underrun_seen", 64'(ur_total > 0), 64'(1));

    prod_on   = 1'b1;
    framerate = 2'b01;
    measure(-1, 2'b01, n, ur);
    measure(-1, 2'b01, n, ur);
    check_eq("t3_recover_period", 64'(n), 64'(160 * H25));

    // Disable mid-frame: frame completes
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n++;
      if (n == 200) enable = 1'b0;
      if (!busy) break;
    end
    check_eq("t5_complete", 64'(n), 64'(160 * H25));

    // Invalid rate stays idle with the line held
    framerate = 2'b10;
    enable    = 1'b1;
    tc_hold   = timecode;
    repeat (600) @(negedge clk);
    check_eq("t5_bad_hold", 64'(timecode), 64'(tc_hold));
    check_eq("t5_bad_busy", 64'(busy), 64'(0));

    // Reset at bit 40
    framerate = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy && bit_index == 7'd40) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t6_reached_bit40", 64'(seen), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t6_timecode", 64'(timecode), 64'(0));
    check_eq("t6_bit_index", 64'(bit_index), 64'(0));
    check_eq("t6_ready", 64'(frm.frame_ready), 64'(1));
    check_eq("t6_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;

    // Randomized operation
    for (int r = 0; r < 30; r++) begin
      enable    = ($urandom_range(0, 9) != 0);
      fr_pick   = 2'($urandom_range(0, 3));
      framerate = fr_pick;
      prod_on   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      repeat ($urandom_range(50, 1500)) @(negedge clk);
    end

    enable = 1'b0;
    repeat (1200) @(negedge clk);
    check_eq("final_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
